// File: rtl/ps2_scancode_decoder_if.sv
// Byte stream from the PS/2 receiver plus the key-event handshake toward the mapper.
// Handshake: an event transfers on a cycle where key_valid && key_ready; head fields hold while key_valid is high.
interface ps2_scancode_decoder_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_error;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_release;
   logic       key_valid;
   logic       key_ready;
   logic       overflow;

   modport master (
      output rx_data, rx_valid, rx_error, key_ready,
      input  key_code, key_ext, key_release, key_valid, overflow
   );

   modport slave (
      input  rx_data, rx_valid, rx_error, key_ready,
      output key_code, key_ext, key_release, key_valid, overflow
   );
endinterface

// File: rtl/ps2_scancode_decoder.sv
// Scan-code set 2 parser: strips E0/F0 prefixes, swallows Pause, replies and fake shifts,
// and queues {ext, rel, code} key events in a show-ahead FIFO.
module ps2_scancode_decoder #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   ps2_scancode_decoder_if.slave  bus,
   output logic [2:0]             o_state
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      EXT    = 3'd1,
      BRK    = 3'd2,
      EXTBRK = 3'd3,
      PAUSE  = 3'd4
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [2:0]  r_pause_cnt, w_pause_cnt_nxt;
   logic        w_emit;
   logic [9:0]  w_event;

   logic [9:0]  r_mem [FIFO_DEPTH];
   logic [AW:0] r_wr_ptr, r_rd_ptr;
   logic        r_overflow;
   logic        w_full, w_empty, w_pop, w_push;
   logic [7:0]  w_b;
   logic        w_prefix;

   assign w_b      = bus.rx_data;
   assign w_prefix = (w_b == 8'hE0) || (w_b == 8'hE1) || (w_b == 8'hF0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_pause_cnt <= 3'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_pause_cnt <= w_pause_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_pause_cnt_nxt = r_pause_cnt;
      w_emit          = 1'b0;
      w_event         = 10'd0;
      if (bus.rx_error) begin
         w_state_nxt     = IDLE;
         w_pause_cnt_nxt = 3'd0;
      end else if (bus.rx_valid) begin
         case (r_state)
            IDLE: begin
               case (w_b)
                  8'hE0: w_state_nxt = EXT;
                  8'hF0: w_state_nxt = BRK;
                  8'hE1: begin
                     w_state_nxt     = PAUSE;
                     w_pause_cnt_nxt = 3'd6;
                  end
                  // controller replies and self-test results, not key transitions
                  8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00: ;
                  default: begin
                     w_emit  = 1'b1;
                     w_event = {2'b00, w_b};
                  end
               endcase
            end
            EXT: begin
               if (w_b == 8'hF0) begin
                  w_state_nxt = EXTBRK;
               end else if (w_b == 8'hE0) begin
                  w_state_nxt = EXT;
               end else begin
                  w_state_nxt = IDLE;
                  if (w_b != 8'h12 && w_b != 8'h59) begin
                     w_emit  = 1'b1;
                     w_event = {2'b10, w_b};
                  end
               end
            end
            BRK: begin
               w_state_nxt = IDLE;
               if (!w_prefix) begin
                  w_emit  = 1'b1;
                  w_event = {2'b01, w_b};
               end
            end
            EXTBRK: begin
               w_state_nxt = IDLE;
               if (!w_prefix && w_b != 8'h12 && w_b != 8'h59) begin
                  w_emit  = 1'b1;
                  w_event = {2'b11, w_b};
               end
            end
            PAUSE: begin
               if (r_pause_cnt == 3'd0) begin
                  w_state_nxt = IDLE;
                  w_emit      = 1'b1;
                  w_event     = {2'b10, 8'h77};
               end else begin
                  w_pause_cnt_nxt = r_pause_cnt - 3'd1;
               end
            end
            default: begin
               w_state_nxt     = IDLE;
               w_pause_cnt_nxt = 3'd0;
            end
         endcase
      end
   end

   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
   assign w_pop   = !w_empty && bus.key_ready;
   // a pop frees the slot this same edge, so a full FIFO still accepts the write
   assign w_push  = w_emit && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_event;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_overflow <= w_emit && w_full && !w_pop;
      end
   end

   // head fields forced to zero when empty so reset shows a clean idle bus
   assign bus.key_valid   = !w_empty;
   assign bus.key_code    = w_empty ? 8'h00 : r_mem[r_rd_ptr[AW-1:0]][7:0];
   assign bus.key_release = w_empty ? 1'b0  : r_mem[r_rd_ptr[AW-1:0]][8];
   assign bus.key_ext     = w_empty ? 1'b0  : r_mem[r_rd_ptr[AW-1:0]][9];
   assign bus.overflow    = r_overflow;
   assign o_state         = r_state;
endmodule
